muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with integrated HI/LO result registers. It executes unsigned and signed multiply and divide on WIDTH-bit operands at one bit per cycle, behind a start/done handshake. It sits in the EX stage beside the ALU and shifter: the pipeline issues an operation, stalls dependent HI/LO reads while `busy`, and reads `hi_out`/`lo_out` through the total-ALU result mux.

---
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers: one bit per cycle,
// start/done handshake, synchronous kill and asynchronous reset.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   mag_a, mag_b, orig_a;
  logic               neg_q, neg_r, b_zero;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;   // mult: {partial product, multiplier}; div: low half is dividend/quotient
  logic [WIDTH:0]     rem;

  logic               is_signed, accept;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH:0]     rem_step;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_signed = op[0];
  assign accept    = (state == IDLE) && start && !kill;
  assign abs_a     = (is_signed && dataA[WIDTH-1]) ? -dataA : dataA;
  assign abs_b     = (is_signed && dataB[WIDTH-1]) ? -dataB : dataB;
  assign busy      = (state != IDLE);

  // Next-state logic; kill overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // One iteration of shift-add or restoring division.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    acc_step  = acc;
    rem_step  = rem;
    if (op_q[1]) begin
      // Bit WIDTH of the difference is set exactly when the trial subtract goes negative.
      rem_step = div_diff[WIDTH] ? div_shift : div_diff;
      acc_step = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      orig_a <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      rem    <= '0;
    end else if (accept) begin
      op_q   <= op;
      mag_a  <= abs_a;
      mag_b  <= abs_b;
      orig_a <= dataA;
      neg_q  <= is_signed && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
      neg_r  <= is_signed && dataA[WIDTH-1];
      b_zero <= (dataB == '0);
      cnt    <= CW'(WIDTH);
      acc    <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
      rem    <= '0;
    end else if (state == CALC) begin
      acc <= acc_step;
      rem <= rem_step;
      cnt <= cnt - CW'(1);
    end
  end

  // Result registers only move at FIX, and never on a killed cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done   <= 1'b0;
      div0   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      done <= 1'b0;
      if (state == FIX && !kill) begin
        done <= 1'b1;
        if (!op_q[1]) begin
          hi_out <= prod_fix[2*WIDTH-1:WIDTH];
          lo_out <= prod_fix[WIDTH-1:0];
        end else if (b_zero) begin
          hi_out <= orig_a;
          lo_out <= '1;
          div0   <= 1'b1;
        end else begin
          hi_out <= rem_fix;
          lo_out <= quo_fix;
          div0   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: scoreboard of expected HI/LO/div0 per issued op,
// plus latency, back-to-back, start-while-busy, kill and async reset checks.
module tb_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, start, kill;
  logic [1:0]    op;
  logic [W-1:0]  dataA, dataB;
  logic          busy, done, div0;
  logic [W-1:0]  hi_out, lo_out;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  logic model_div0 = 1'b0;
  logic [W-1:0] last_hi = '0, last_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dataA(dataA), .dataB(dataB),
    .kill(kill), .busy(busy), .done(done), .div0(div0), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour from native arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic dz_prev);
    exp_t r;
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r.dz = dz_prev;
    case (o)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b01: begin p = 64'(sa * sb); r.hi = p[63:32]; r.lo = p[31:0]; end
      default: begin
        if (b == '0) begin
          r.hi = a; r.lo = '1; r.dz = 1'b1;
        end else if (o == 2'b10) begin
          r.hi = a % b; r.lo = a / b; r.dz = 1'b0;
        end else begin
          p = 64'(sa / sb); r.lo = p[31:0];
          p = 64'(sa % sb); r.hi = p[31:0];
          r.dz = 1'b0;
        end
      end
    endcase
    return r;
  endfunction

  // Issue one op (returns in the done cycle); optionally pulse start again at cycle ign_at.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int ign_at);
    exp_t e;
    int n, bcnt;
    e = model(o, a, b, model_div0);
    q.push_back(e);
    model_div0 = e.dz;
    op = o; dataA = a; dataB = b; start = 1'b1;
    step();
    start = 1'b0;
    dataA = $urandom; dataB = $urandom; op = ~o;
    n = 0; bcnt = 0;
    while (!done && n < 100) begin
      if (busy) bcnt++;
      if (n == ign_at) start = 1'b1;
      step();
      start = 1'b0;
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'd33);
    chk({tag, ".busy_cycles"}, 64'(bcnt), 64'd33);
    chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    if (q.size() == 0) begin
      failures++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".hi"}, 64'(hi_out), 64'(e.hi));
      chk({tag, ".lo"}, 64'(lo_out), 64'(e.lo));
      chk({tag, ".div0"}, 64'(div0), 64'(e.dz));
      last_hi = e.hi; last_lo = e.lo;
    end
  endtask

  initial begin
    int n, seen;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; dataA = '0; dataB = '0;
    #12;
    chk("reset.busy", 64'(busy), 0);
    chk("reset.done", 64'(done), 0);
    chk("reset.div0", 64'(div0), 0);
    chk("reset.hilo", {hi_out, lo_out}, 0);
    rst = 1'b0;
    step();

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("multu_max.const", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, -1);
    chk("mult_neg.const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("mult_b2b", 2'b01, 32'h8000_0000, 32'h8000_0000, -1);
    chk("mult_b2b.const", {hi_out, lo_out}, 64'h4000_0000_0000_0000);
    run_op("divu", 2'b10, 32'd100, 32'd7, -1);
    chk("divu.const", {hi_out, lo_out}, {32'd2, 32'd14});
    run_op("div_negA", 2'b11, 32'hFFFF_FFF9, 32'd2, -1);
    chk("div_negA.const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("div_negB", 2'b11, 32'd7, 32'hFFFF_FFFE, -1);
    chk("div_negB.const", {hi_out, lo_out}, 64'h0000_0001_FFFF_FFFD);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("div_ovf.const", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
    run_op("divu_zero", 2'b10, 32'd5, 32'd0, -1);
    chk("divu_zero.const", {hi_out, lo_out, 31'b0, div0}, {32'd5, 32'hFFFF_FFFF, 32'd1});
    run_op("mult_keep_div0", 2'b00, 32'd3, 32'd4, -1);
    run_op("divu_clr", 2'b10, 32'd9, 32'd3, -1);
    chk("divu_clr.const", {hi_out, lo_out, 31'b0, div0}, {32'd0, 32'd3, 32'd0});

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = (i % 2) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 3 == 0) b = -b;
      run_op("rand", 2'(i % 4), a, b, -1);
    end

    // start pulse while busy must not queue a second op
    run_op("ign_start", 2'b10, 32'd1000, 32'd33, 5);
    step();
    chk("ign_start.no_second_busy", 64'(busy), 0);
    chk("ign_start.done_one_cycle", 64'(done), 0);

    // kill at cycle 10
    op = 2'b00; dataA = 32'd11; dataB = 32'd13; start = 1'b1;
    step();
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin step(); if (done) seen++; end
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill.busy_low", 64'(busy), 0);
    for (int i = 0; i < 40; i++) begin step(); if (done) seen++; end
    chk("kill.no_done", 64'(seen), 0);
    chk("kill.hilo_kept", {hi_out, lo_out}, {last_hi, last_lo});
    chk("kill.div0_kept", 64'(div0), 64'(model_div0));

    // async reset at cycle 17 of a divide (div0 set first so the clear is visible)
    run_op("pre_rst_dz", 2'b10, 32'd77, 32'd0, -1);
    op = 2'b10; dataA = 32'd500; dataB = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 17; i++) step();
    #2 rst = 1'b1;
    #1;
    chk("arst.busy", 64'(busy), 0);
    chk("arst.done", 64'(done), 0);
    chk("arst.div0", 64'(div0), 0);
    chk("arst.hilo", {hi_out, lo_out}, 0);
    model_div0 = 1'b0;
    step();
    rst = 1'b0;
    step();
    run_op("post_rst", 2'b00, 32'd6, 32'd7, -1);
    chk("post_rst.const", {hi_out, lo_out}, 64'd42);

    n = q.size();
    chk("scoreboard.drained", 64'(n), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
